// File: rtl/dex_hazard_scoreboard.sv
// Decode-execute hazard scoreboard: tracks in-flight destination registers, forwards
// ready results to the read ports, injects bubbles on RAW hazards and owns the WAIT stall counter.
module dex_hazard_scoreboard #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int DEPTH  = 2,
    parameter int WAIT_W = 11
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           issue_valid,
    input  logic [NUM_RD-1:0]              rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]       rd_addr,
    input  logic [NUM_WR-1:0]              wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]       wr_addr,
    input  logic [DEPTH*NUM_WR-1:0]        stage_rdy,
    input  logic [DEPTH*NUM_WR*DATA_W-1:0] stage_data,
    input  logic                           stall_ext,
    input  logic                           wait_start,
    input  logic [WAIT_W-1:0]              wait_cycles,
    output logic                           stall,
    output logic                           bubble,
    output logic                           wait_busy,
    output logic                           issue_accept,
    output logic [NUM_RD-1:0]              fwd_sel,
    output logic [NUM_RD*DATA_W-1:0]       fwd_data
);

    typedef enum logic {
        S_RUN,
        S_WAIT
    } state_t;

    localparam logic [WAIT_W-1:0] CNT_ONE = 1;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] cnt, cnt_nxt;

    logic              slot_valid [DEPTH][NUM_WR];
    logic [ADDR_W-1:0] slot_addr  [DEPTH][NUM_WR];

    logic [NUM_RD-1:0] hit;
    logic [NUM_RD-1:0] hit_rdy;
    logic [DATA_W-1:0] hit_data [NUM_RD];
    logic [NUM_RD-1:0] hazard;

    // Oldest-to-youngest scan so the last match written is the youngest producer
    // (lowest slot, then highest channel, matching regfile write priority).
    always_comb begin
        fwd_sel  = '0;
        fwd_data = '0;
        hazard   = '0;
        hit      = '0;
        hit_rdy  = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            hit_data[i] = '0;
            for (int s = DEPTH - 1; s >= 0; s--) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (rd_en[i] && issue_valid && slot_valid[s][j] &&
                        (slot_addr[s][j] == rd_addr[i*ADDR_W +: ADDR_W])) begin
                        hit[i]      = 1'b1;
                        hit_rdy[i]  = stage_rdy[s*NUM_WR + j];
                        hit_data[i] = stage_data[(s*NUM_WR + j)*DATA_W +: DATA_W];
                    end
                end
            end
            fwd_sel[i] = hit[i] & hit_rdy[i] & ~rst;
            if (fwd_sel[i]) begin
                fwd_data[i*DATA_W +: DATA_W] = hit_data[i];
            end
            hazard[i] = hit[i] & ~hit_rdy[i];
        end
    end

    assign wait_busy    = (state == S_WAIT) & ~rst;
    assign bubble       = (|hazard) & ~stall_ext & ~wait_busy & ~rst;
    assign stall        = stall_ext | wait_busy | bubble;
    assign issue_accept = issue_valid & ~stall & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The WAIT counter keeps running under an external stall.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_RUN: begin
                if (issue_accept && wait_start && (wait_cycles != '0)) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = wait_cycles;
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    state_nxt = S_RUN;
                end
            end
            default: begin
                state_nxt = S_RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Bubbles and idle cycles shift in an empty slot so older producers keep draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    slot_valid[s][j] <= 1'b0;
                    slot_addr[s][j]  <= '0;
                end
            end
        end else if (!(stall_ext || wait_busy)) begin
            for (int s = 1; s < DEPTH; s++) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    slot_valid[s][j] <= slot_valid[s-1][j];
                    slot_addr[s][j]  <= slot_addr[s-1][j];
                end
            end
            for (int j = 0; j < NUM_WR; j++) begin
                slot_valid[0][j] <= issue_accept & wr_en[j];
                slot_addr[0][j]  <= wr_addr[j*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: tb/tb_dex_hazard_scoreboard.sv
// Directed self-checking bench for dex_hazard_scoreboard with the default parameters
// (2 read ports, 2 write channels, 2 slots).
module tb_dex_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [3:0]  stage_rdy;
    logic [63:0] stage_data;
    logic        stall_ext;
    logic        wait_start;
    logic [10:0] wait_cycles;
    logic        stall;
    logic        bubble;
    logic        wait_busy;
    logic        issue_accept;
    logic [1:0]  fwd_sel;
    logic [31:0] fwd_data;

    // {stall, bubble, wait_busy, issue_accept, fwd_sel[1:0]}
    logic [5:0]  flags;
    assign flags = {stall, bubble, wait_busy, issue_accept, fwd_sel};

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dex_hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .stage_rdy    (stage_rdy),
        .stage_data   (stage_data),
        .stall_ext    (stall_ext),
        .wait_start   (wait_start),
        .wait_cycles  (wait_cycles),
        .stall        (stall),
        .bubble       (bubble),
        .wait_busy    (wait_busy),
        .issue_accept (issue_accept),
        .fwd_sel      (fwd_sel),
        .fwd_data     (fwd_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        issue_valid = 1'b0;
        rd_en       = '0;
        rd_addr     = '0;
        wr_en       = '0;
        wr_addr     = '0;
        stage_rdy   = '0;
        stage_data  = '0;
        stall_ext   = 1'b0;
        wait_start  = 1'b0;
        wait_cycles = '0;
    endtask

    task automatic drain();
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic issue_write(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1);
        clear_inputs();
        issue_valid = 1'b1;
        wr_en       = en;
        wr_addr     = {a1, a0};
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        issue_valid = 1'b1;
        rd_en       = 2'b11;
        rd_addr     = {5'd5, 5'd0};
        stage_rdy   = 4'hF;
        stage_data  = 64'h1234_5678_9ABC_DEF0;
        #1;
        total++;
        if (flags !== 6'b000000) $display("[TB] FAIL reset_flags got %b expected %b", flags, 6'b000000);
        else passed++;
        total++;
        if (fwd_data !== 32'h0) $display("[TB] FAIL reset_fwd_data got %h expected %h", fwd_data, 32'h0);
        else passed++;
        stall_ext = 1'b1;
        #1;
        total++;
        if (flags !== 6'b100000) $display("[TB] FAIL reset_stall_ext got %b expected %b", flags, 6'b100000);
        else passed++;
        stall_ext = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (flags !== 6'b000100) $display("[TB] FAIL reset_release got %b expected %b", flags, 6'b000100);
        else passed++;
        total++;
        if (fwd_data !== 32'h0) $display("[TB] FAIL reset_release_data got %h expected %h", fwd_data, 32'h0);
        else passed++;
        tick();
        drain();
    endtask

    task automatic test_forward();
        issue_write(2'b01, 5'd5, 5'd0);
        clear_inputs();
        issue_valid       = 1'b1;
        rd_en             = 2'b01;
        rd_addr           = {5'd0, 5'd5};
        stage_rdy         = 4'b0001;
        stage_data[15:0]  = 16'hBEEF;
        #1;
        total++;
        if (flags !== 6'b000101) $display("[TB] FAIL fwd_slot0_flags got %b expected %b", flags, 6'b000101);
        else passed++;
        total++;
        if (fwd_data !== 32'h0000_BEEF) $display("[TB] FAIL fwd_slot0_data got %h expected %h", fwd_data, 32'h0000_BEEF);
        else passed++;
        tick();
        clear_inputs();
        issue_valid       = 1'b1;
        rd_en             = 2'b10;
        rd_addr           = {5'd5, 5'd0};
        stage_rdy         = 4'b0100;
        stage_data[47:32] = 16'h1234;
        #1;
        total++;
        if (flags !== 6'b000110) $display("[TB] FAIL fwd_slot1_flags got %b expected %b", flags, 6'b000110);
        else passed++;
        total++;
        if (fwd_data !== 32'h1234_0000) $display("[TB] FAIL fwd_slot1_data got %h expected %h", fwd_data, 32'h1234_0000);
        else passed++;
        tick();
        drain();
    endtask

    task automatic test_bubble();
        issue_write(2'b01, 5'd5, 5'd0);
        clear_inputs();
        issue_valid = 1'b1;
        rd_en       = 2'b01;
        rd_addr     = {5'd0, 5'd5};
        #1;
        total++;
        if (flags !== 6'b110000) $display("[TB] FAIL bubble_flags got %b expected %b", flags, 6'b110000);
        else passed++;
        total++;
        if (fwd_data !== 32'h0) $display("[TB] FAIL bubble_data got %h expected %h", fwd_data, 32'h0);
        else passed++;
        tick();
        stage_rdy         = 4'b0100;
        stage_data[47:32] = 16'hCAFE;
        #1;
        total++;
        if (flags !== 6'b000101) $display("[TB] FAIL bubble_release_flags got %b expected %b", flags, 6'b000101);
        else passed++;
        total++;
        if (fwd_data !== 32'h0000_CAFE) $display("[TB] FAIL bubble_release_data got %h expected %h", fwd_data, 32'h0000_CAFE);
        else passed++;
        tick();
        drain();
    endtask

    task automatic test_priority();
        issue_write(2'b01, 5'd3, 5'd0);
        issue_write(2'b10, 5'd0, 5'd3);
        clear_inputs();
        issue_valid = 1'b1;
        rd_en       = 2'b01;
        rd_addr     = {5'd0, 5'd3};
        stage_rdy   = 4'b0100;
        stage_data  = {16'h0000, 16'h1111, 16'h2222, 16'h0000};
        #1;
        total++;
        if (flags !== 6'b110000) $display("[TB] FAIL prio_young_not_ready got %b expected %b", flags, 6'b110000);
        else passed++;
        stage_rdy = 4'b1111;
        #1;
        total++;
        if (flags !== 6'b000101) $display("[TB] FAIL prio_slot_flags got %b expected %b", flags, 6'b000101);
        else passed++;
        total++;
        if (fwd_data !== 32'h0000_2222) $display("[TB] FAIL prio_slot_data got %h expected %h", fwd_data, 32'h0000_2222);
        else passed++;
        tick();
        drain();
        issue_write(2'b11, 5'd7, 5'd7);
        clear_inputs();
        issue_valid = 1'b1;
        rd_en       = 2'b10;
        rd_addr     = {5'd7, 5'd0};
        stage_rdy   = 4'b0011;
        stage_data  = {32'h0, 16'hBBBB, 16'hAAAA};
        #1;
        total++;
        if (flags !== 6'b000110) $display("[TB] FAIL prio_channel_flags got %b expected %b", flags, 6'b000110);
        else passed++;
        total++;
        if (fwd_data !== 32'hBBBB_0000) $display("[TB] FAIL prio_channel_data got %h expected %h", fwd_data, 32'hBBBB_0000);
        else passed++;
        tick();
        drain();
    endtask

    task automatic test_wait();
        clear_inputs();
        issue_valid = 1'b1;
        wait_start  = 1'b1;
        wait_cycles = 11'd4;
        wr_en       = 2'b01;
        wr_addr     = {5'd0, 5'd9};
        #1;
        total++;
        if (flags !== 6'b000100) $display("[TB] FAIL wait_accept got %b expected %b", flags, 6'b000100);
        else passed++;
        tick();
        clear_inputs();
        issue_valid      = 1'b1;
        rd_en            = 2'b01;
        rd_addr          = {5'd0, 5'd9};
        stage_rdy        = 4'b0001;
        stage_data[15:0] = 16'h0F0F;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++;
            if (flags !== 6'b101001) $display("[TB] FAIL wait_busy_cycle%0d got %b expected %b", k, flags, 6'b101001);
            else passed++;
            tick();
        end
        #1;
        total++;
        if (flags !== 6'b000101) $display("[TB] FAIL wait_release_flags got %b expected %b", flags, 6'b000101);
        else passed++;
        total++;
        if (fwd_data !== 32'h0000_0F0F) $display("[TB] FAIL wait_frozen_data got %h expected %h", fwd_data, 32'h0000_0F0F);
        else passed++;
        tick();
        drain();
        clear_inputs();
        issue_valid = 1'b1;
        wait_start  = 1'b1;
        wait_cycles = 11'd0;
        tick();
        clear_inputs();
        issue_valid = 1'b1;
        #1;
        total++;
        if (flags !== 6'b000100) $display("[TB] FAIL wait_zero_nostall got %b expected %b", flags, 6'b000100);
        else passed++;
        tick();
        drain();
    endtask

    task automatic test_wait_reset();
        clear_inputs();
        issue_valid = 1'b1;
        wait_start  = 1'b1;
        wait_cycles = 11'd4;
        wr_en       = 2'b01;
        wr_addr     = {5'd0, 5'd9};
        tick();
        clear_inputs();
        issue_valid      = 1'b1;
        rd_en            = 2'b01;
        rd_addr          = {5'd0, 5'd9};
        stage_rdy        = 4'b0001;
        stage_data[15:0] = 16'h7777;
        tick();
        tick();
        #1;
        total++;
        if (flags !== 6'b101001) $display("[TB] FAIL wait_cnt2_busy got %b expected %b", flags, 6'b101001);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if (flags !== 6'b000000) $display("[TB] FAIL reset_mid_wait got %b expected %b", flags, 6'b000000);
        else passed++;
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (flags !== 6'b000100) $display("[TB] FAIL after_reset_flags got %b expected %b", flags, 6'b000100);
        else passed++;
        total++;
        if (fwd_data !== 32'h0) $display("[TB] FAIL after_reset_data got %h expected %h", fwd_data, 32'h0);
        else passed++;
        tick();
        drain();
    endtask

    task automatic test_stall_ext();
        issue_write(2'b01, 5'd6, 5'd0);
        clear_inputs();
        issue_valid = 1'b1;
        rd_en       = 2'b01;
        rd_addr     = {5'd0, 5'd6};
        stall_ext   = 1'b1;
        #1;
        total++;
        if (flags !== 6'b100000) $display("[TB] FAIL stallext_hazard got %b expected %b", flags, 6'b100000);
        else passed++;
        tick();
        stall_ext        = 1'b0;
        stage_rdy        = 4'b0001;
        stage_data[15:0] = 16'h5A5A;
        #1;
        total++;
        if (flags !== 6'b000101) $display("[TB] FAIL stallext_hold_flags got %b expected %b", flags, 6'b000101);
        else passed++;
        total++;
        if (fwd_data !== 32'h0000_5A5A) $display("[TB] FAIL stallext_hold_data got %h expected %h", fwd_data, 32'h0000_5A5A);
        else passed++;
        tick();
        drain();
        clear_inputs();
        issue_valid = 1'b1;
        wait_start  = 1'b1;
        wait_cycles = 11'd3;
        tick();
        clear_inputs();
        issue_valid = 1'b1;
        stall_ext   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (flags !== 6'b101000) $display("[TB] FAIL wait_stallext_cycle%0d got %b expected %b", k, flags, 6'b101000);
            else passed++;
            tick();
        end
        stall_ext = 1'b0;
        #1;
        total++;
        if (flags !== 6'b000100) $display("[TB] FAIL wait_stallext_done got %b expected %b", flags, 6'b000100);
        else passed++;
        tick();
        drain();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout after %0d checks", total);
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_forward();
        test_bubble();
        test_priority();
        test_wait();
        test_wait_reset();
        test_stall_ext();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
